// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus CPU.
// A T-state counter walks fetch (T0,T1) and execute (T2..T4) and the
// {opcode, step, flags} tuple is decoded into a 15-bit control word.
// Optional feature macro: CTRL_EARLY_FETCH_EN -- when defined, each
// instruction returns to T0 right after its last non-empty microstep.
module control_sequencer #(
  parameter int STEPS    = 5,
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                carry_flag,
  input  logic                zero_flag,
  output logic [14:0]         ctrl,
  output logic                hlt,
  output logic [2:0]          step
);

  // Control word bit positions
  localparam int B_PC_INC   = 14;
  localparam int B_PC_JUMP  = 13;
  localparam int B_PC_OUT   = 12;
  localparam int B_MAR_IN   = 11;
  localparam int B_RAM_IN   = 10;
  localparam int B_RAM_OUT  = 9;
  localparam int B_IR_IN    = 8;
  localparam int B_IR_OUT   = 7;
  localparam int B_A_IN     = 6;
  localparam int B_A_OUT    = 5;
  localparam int B_B_IN     = 4;
  localparam int B_ALU_OUT  = 3;
  localparam int B_ALU_SUB  = 2;
  localparam int B_FLAGS_IN = 1;
  localparam int B_OUT_IN   = 0;

  localparam logic [OPCODE_W-1:0] OP_NOP = OPCODE_W'(4'h0);
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'h1);
  localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'h2);
  localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'h3);
  localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'h4);
  localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'h5);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'h6);
  localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'h7);
  localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'h8);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'hE);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'hF);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [14:0] decode;
  logic        hlt_decode;
  logic [2:0]  last_step;

  // Microcode ROM: control word for the current opcode/step/flags
  always_comb begin
    decode = '0;
    case (step_reg)
      3'd0: begin
        decode[B_PC_OUT] = 1'b1;
        decode[B_MAR_IN] = 1'b1;
      end
      3'd1: begin
        decode[B_RAM_OUT] = 1'b1;
        decode[B_IR_IN]   = 1'b1;
        decode[B_PC_INC]  = 1'b1;
      end
      3'd2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            decode[B_IR_OUT] = 1'b1;
            decode[B_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            decode[B_IR_OUT] = 1'b1;
            decode[B_A_IN]   = 1'b1;
          end
          OP_JMP: begin
            decode[B_IR_OUT]  = 1'b1;
            decode[B_PC_JUMP] = 1'b1;
          end
          OP_JC: begin
            decode[B_IR_OUT]  = carry_flag;
            decode[B_PC_JUMP] = carry_flag;
          end
          OP_JZ: begin
            decode[B_IR_OUT]  = zero_flag;
            decode[B_PC_JUMP] = zero_flag;
          end
          OP_OUT: begin
            decode[B_A_OUT]  = 1'b1;
            decode[B_OUT_IN] = 1'b1;
          end
          default: decode = '0;
        endcase
      end
      3'd3: begin
        case (opcode)
          OP_LDA: begin
            decode[B_RAM_OUT] = 1'b1;
            decode[B_A_IN]    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            decode[B_RAM_OUT] = 1'b1;
            decode[B_B_IN]    = 1'b1;
            decode[B_ALU_SUB] = (opcode == OP_SUB);
          end
          OP_STA: begin
            decode[B_A_OUT]  = 1'b1;
            decode[B_RAM_IN] = 1'b1;
          end
          default: decode = '0;
        endcase
      end
      3'd4: begin
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          decode[B_ALU_OUT]  = 1'b1;
          decode[B_A_IN]     = 1'b1;
          decode[B_FLAGS_IN] = 1'b1;
          decode[B_ALU_SUB]  = (opcode == OP_SUB);
        end
      end
      default: decode = '0;
    endcase
  end

  // Last microstep of the current instruction (wrap point of the counter)
  always_comb begin
    last_step = LAST_STEP;
`ifdef CTRL_EARLY_FETCH_EN
    case (opcode)
      OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT: last_step = 3'd2;
      OP_LDA, OP_STA:                       last_step = 3'd3;
      OP_ADD, OP_SUB:                       last_step = 3'd4;
      OP_HLT:                               last_step = LAST_STEP;
      default:                              last_step = 3'd1;
    endcase
`endif
  end

  // Next-state logic and gated outputs
  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    hlt_decode = (state_reg == RUN) && (step_reg == 3'd2) && (opcode == OP_HLT);
    if (step_en && state_reg == RUN) begin
      if (hlt_decode) begin
        state_next = HALTED;
      end else if (step_reg == last_step) begin
        step_next = 3'd0;
      end else begin
        step_next = step_reg + 3'd1;
      end
    end
    // Outputs are forced low while reset is asserted, not decoded
    ctrl = (rst && state_reg == RUN) ? decode : '0;
    hlt  = rst && ((state_reg == HALTED) || hlt_decode);
    step = step_reg;
  end

  // State register: T-state counter and halt latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
      step_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

endmodule
